// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode and flag types shared by alu_core and alu_pipe
package alu_pkg;

    localparam int ALU_OP_BITS = 4;

    // Opcodes 12-15 are intentionally unassigned and decode as "undefined".
    typedef enum logic [ALU_OP_BITS-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_ADC   = 4'd2,
        OP_SBC   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_SHL   = 4'd7,
        OP_SHR   = 4'd8,
        OP_ASR   = 4'd9,
        OP_PASSB = 4'd10,
        OP_MUL   = 4'd11
    } alu_op_t;

    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } alu_flags_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath; multiplier present only with ALU_PIPE_MUL_EN
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  alu_op_t              op_i,
    input  logic [DATA_BITS-1:0] a_i,
    input  logic [DATA_BITS-1:0] b_i,
    input  logic                 cin_i,
    output logic [DATA_BITS-1:0] result_o,
    output alu_flags_t           flags_o
);

    localparam int AW = $clog2(DATA_BITS);

    logic [DATA_BITS-1:0] b_x;
    logic                 carry_in;
    logic [DATA_BITS:0]   sum;
    logic [AW-1:0]        amt;
    logic [DATA_BITS:0]   shl_ext;
    logic [DATA_BITS:0]   shr_ext;
    logic [DATA_BITS:0]   asr_ext;
    logic [DATA_BITS-1:0] res;
    logic                 c;
    logic                 v;

    // Subtraction is a + ~b + carry, so C=1 means "no borrow".
    assign b_x = (op_i == OP_SUB || op_i == OP_SBC) ? ~b_i : b_i;
    assign sum = {1'b0, a_i} + {1'b0, b_x} + {{DATA_BITS{1'b0}}, carry_in};

    // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
    assign amt     = b_i[AW-1:0];
    assign shl_ext = {1'b0, a_i} << amt;
    assign shr_ext = {a_i, 1'b0} >> amt;
    assign asr_ext = $signed({a_i, 1'b0}) >>> amt;

`ifdef ALU_PIPE_MUL_EN
    logic [2*DATA_BITS-1:0] prod;
    assign prod = {{DATA_BITS{1'b0}}, a_i} * {{DATA_BITS{1'b0}}, b_i};
`endif

    // Carry-in selection for the shared adder.
    always_comb begin
        carry_in = 1'b0;
        case (op_i)
            OP_SUB:         carry_in = 1'b1;
            OP_ADC, OP_SBC: carry_in = cin_i;
            default:        carry_in = 1'b0;
        endcase
    end

    // Result and flag selection; undefined ops yield zero, which makes Z=1 and the rest 0.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res = sum[DATA_BITS-1:0];
                c   = sum[DATA_BITS];
                v   = (a_i[DATA_BITS-1] == b_x[DATA_BITS-1]) &&
                      (sum[DATA_BITS-1] != a_i[DATA_BITS-1]);
            end
            OP_AND:   res = a_i & b_i;
            OP_OR:    res = a_i | b_i;
            OP_XOR:   res = a_i ^ b_i;
            OP_SHL: begin
                res = shl_ext[DATA_BITS-1:0];
                c   = shl_ext[DATA_BITS];
            end
            OP_SHR: begin
                res = shr_ext[DATA_BITS:1];
                c   = shr_ext[0];
            end
            OP_ASR: begin
                res = asr_ext[DATA_BITS:1];
                c   = asr_ext[0];
            end
            OP_PASSB: res = b_i;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin
                res = prod[DATA_BITS-1:0];
                c   = |prod[2*DATA_BITS-1:DATA_BITS];
            end
`endif
            default:  res = '0;
        endcase
        result_o  = res;
        flags_o.v = v;
        flags_o.n = res[DATA_BITS-1];
        flags_o.c = c;
        flags_o.z = (res == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline; optional multiply via ALU_PIPE_MUL_EN
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OP_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_BITS-1:0]   in_op,
    input  logic [DATA_BITS-1:0] in_a,
    input  logic [DATA_BITS-1:0] in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_result,
    output logic [3:0]           out_flags
);

    logic                 s1_valid_q, s1_valid_d;
    alu_op_t              s1_op_q,    s1_op_d;
    logic [DATA_BITS-1:0] s1_a_q,     s1_a_d;
    logic [DATA_BITS-1:0] s1_b_q,     s1_b_d;
    logic                 s1_cin_q,   s1_cin_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [DATA_BITS-1:0] s2_result_q, s2_result_d;
    alu_flags_t           s2_flags_q,  s2_flags_d;

    logic [DATA_BITS-1:0] core_result;
    alu_flags_t           core_flags;
    logic                 adv2;

    alu_core #(.DATA_BITS(DATA_BITS)) u_core (
        .op_i     (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .cin_i    (s1_cin_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // Stage 2 moves whenever it is empty or being drained; stage 1 follows it, so a full
    // pipe with both sides ready still advances every cycle.
    assign adv2       = ~s2_valid_q | out_ready;
    assign in_ready   = ~s1_valid_q | adv2;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_flags  = s2_flags_q;

    // Next-state for both stages; data registers only load on a real transfer.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_cin_d    = s1_cin_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d  = alu_op_t'(in_op);
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_cin_d = in_cin;
            end
        end
        if (adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_flags_d  = core_flags;
            end
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

endmodule
